// File: rtl/ioq_hdr_inserter_pkg.sv
// Shared IOQ module-header definitions: field positions, header ctrl value and byte-count helpers.
// Optional runt dropping in ioq_hdr_inserter is enabled with `define IOQ_HDR_INS_RUNT_DROP_EN.
`ifndef IO_QUEUE_STAGE_NUM
`define IO_QUEUE_STAGE_NUM 8'hff
`endif
`ifndef IOQ_BYTE_LEN_POS
`define IOQ_BYTE_LEN_POS 0
`endif
`ifndef IOQ_SRC_PORT_POS
`define IOQ_SRC_PORT_POS 16
`endif
`ifndef IOQ_WORD_LEN_POS
`define IOQ_WORD_LEN_POS 32
`endif
`ifndef IOQ_DST_PORT_POS
`define IOQ_DST_PORT_POS 48
`endif

package ioq_hdr_inserter_pkg;

  localparam int IOQ_BYTE_LEN_POS = `IOQ_BYTE_LEN_POS;
  localparam int IOQ_SRC_PORT_POS = `IOQ_SRC_PORT_POS;
  localparam int IOQ_WORD_LEN_POS = `IOQ_WORD_LEN_POS;
  localparam int IOQ_DST_PORT_POS = `IOQ_DST_PORT_POS;

  typedef enum logic {
    EG_IDLE = 1'b0,
    EG_DATA = 1'b1
  } eg_state_t;

  // Final-word ctrl to valid byte count; malformed (multi-bit) ctrl counts as a full word.
  function automatic logic [3:0] onehot_to_bytes(input logic [7:0] ctrl);
    case (ctrl)
      8'h80:   return 4'd1;
      8'h40:   return 4'd2;
      8'h20:   return 4'd3;
      8'h10:   return 4'd4;
      8'h08:   return 4'd5;
      8'h04:   return 4'd6;
      8'h02:   return 4'd7;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [63:0] make_hdr(input logic [15:0] byte_len,
                                           input logic [15:0] word_len,
                                           input logic [15:0] src_port);
    logic [63:0] h;
    h = '0;
    h[IOQ_BYTE_LEN_POS +: 16] = byte_len;
    h[IOQ_SRC_PORT_POS +: 16] = src_port;
    h[IOQ_WORD_LEN_POS +: 16] = word_len;
    h[IOQ_DST_PORT_POS +: 16] = 16'd0;
    return h;
  endfunction

endpackage

// File: rtl/ioq_pkt_fifo.sv
// Synchronous FIFO with combinational read data and an optional committed write pointer.
// With COMMIT_EN the reader only sees words up to the last commit; rewind discards the rest.
module ioq_pkt_fifo #(
  parameter int WIDTH      = 72,
  parameter int DEPTH_BITS = 9,
  parameter bit COMMIT_EN  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      din,
  input  logic                  commit,
  input  logic                  rewind,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_BITS:0]   used
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] PTR_ONE = (DEPTH_BITS+1)'(1);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_BITS:0] wr_ptr;
  logic [DEPTH_BITS:0] rd_ptr;
  logic [DEPTH_BITS:0] vis_ptr;
  logic                do_wr;
  logic                do_rd;

  assign used  = wr_ptr - rd_ptr;
  assign full  = used[DEPTH_BITS];
  assign empty = (rd_ptr == vis_ptr);
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;
  assign dout  = mem[rd_ptr[DEPTH_BITS-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[DEPTH_BITS-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (COMMIT_EN && rewind) wr_ptr <= vis_ptr;
      else if (do_wr)          wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd)               rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  generate
    if (COMMIT_EN) begin : g_commit
      logic [DEPTH_BITS:0] commit_ptr;
      // The committing word itself is part of the committed region.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    commit_ptr <= '0;
        else if (commit) commit_ptr <= wr_ptr + (do_wr ? PTR_ONE : '0);
      end
      assign vis_ptr = commit_ptr;
    end else begin : g_plain
      logic unused_commit;
      assign unused_commit = commit ^ rewind;
      assign vis_ptr = wr_ptr;
    end
  endgenerate

endmodule

// File: rtl/ioq_hdr_inserter.sv
// Buffers raw packets, measures them, and emits an IOQ module header ahead of each packet.
// `define IOQ_HDR_INS_RUNT_DROP_EN discards packets shorter than MIN_PKT_BYTES.
module ioq_hdr_inserter
  import ioq_hdr_inserter_pkg::*;
#(
  parameter int DATA_WIDTH          = 64,
  parameter int CTRL_WIDTH          = DATA_WIDTH/8,
  parameter int SRC_PORT_NUM        = 0,
  parameter int PKT_FIFO_DEPTH_BITS = 9,
  parameter int LEN_FIFO_DEPTH_BITS = 3,
  parameter int IO_QUEUE_STAGE_NUM  = `IO_QUEUE_STAGE_NUM,
  parameter int MIN_PKT_BYTES       = 60
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic                  runt_drop
);

  localparam int PKT_AW = PKT_FIFO_DEPTH_BITS + 1;
  localparam logic [PKT_AW-1:0] PKT_RDY_MAX = PKT_AW'((1 << PKT_FIFO_DEPTH_BITS) - 2);

  // Handshake: in_wr is a word transfer only when in_rdy is high in that cycle; out_rdy high at
  // a clock edge lets the egress present one word (out_wr) in the next cycle, which the
  // downstream must accept.

  logic                              rdy_en;
  logic                              wr_acc;
  logic                              is_eop;
  logic [3:0]                        eop_bytes;
  logic [15:0]                       word_cnt;
  logic [15:0]                       byte_cnt;
  logic [15:0]                       pkt_words;
  logic [15:0]                       pkt_bytes;
  logic                              len_push;
  logic                              pkt_commit;
  logic                              pkt_rewind;
  logic [PKT_AW-1:0]                 pkt_used;
  logic                              pkt_empty;
  logic                              pkt_pop;
  logic [CTRL_WIDTH+DATA_WIDTH-1:0]  pkt_dout;
  logic [31:0]                       len_dout;
  logic                              len_empty;
  logic                              len_full;
  logic                              len_pop;
  logic                              unused_pkt_full;
  logic [LEN_FIFO_DEPTH_BITS:0]      unused_len_used;
  eg_state_t                         eg_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdy_en <= 1'b0;
    else          rdy_en <= 1'b1;
  end

  assign in_rdy    = rdy_en & (pkt_used <= PKT_RDY_MAX) & ~len_full;
  assign wr_acc    = in_wr & in_rdy;
  assign is_eop    = wr_acc & (in_ctrl != '0);
  assign eop_bytes = onehot_to_bytes(in_ctrl);
  assign pkt_words = word_cnt + 16'd1;
  assign pkt_bytes = byte_cnt + {12'd0, eop_bytes};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_cnt <= '0;
      byte_cnt <= '0;
    end else if (wr_acc) begin
      if (is_eop) begin
        word_cnt <= '0;
        byte_cnt <= '0;
      end else begin
        word_cnt <= pkt_words;
        byte_cnt <= byte_cnt + 16'd8;
      end
    end
  end

`ifdef IOQ_HDR_INS_RUNT_DROP_EN
  localparam bit COMMIT_EN = 1'b1;
  logic is_runt;
  logic runt_q;
  assign is_runt    = pkt_bytes < 16'(MIN_PKT_BYTES);
  assign len_push   = is_eop & ~is_runt;
  assign pkt_commit = len_push;
  assign pkt_rewind = is_eop & is_runt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) runt_q <= 1'b0;
    else          runt_q <= pkt_rewind;
  end
  assign runt_drop = runt_q;
`else
  localparam bit COMMIT_EN = 1'b0;
  logic [15:0] unused_min_bytes;
  assign unused_min_bytes = 16'(MIN_PKT_BYTES);
  assign len_push   = is_eop;
  assign pkt_commit = 1'b0;
  assign pkt_rewind = 1'b0;
  assign runt_drop  = 1'b0;
`endif

  ioq_pkt_fifo #(
    .WIDTH      (CTRL_WIDTH + DATA_WIDTH),
    .DEPTH_BITS (PKT_FIFO_DEPTH_BITS),
    .COMMIT_EN  (COMMIT_EN)
  ) u_pkt_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_acc),
    .din     ({in_ctrl, in_data}),
    .commit  (pkt_commit),
    .rewind  (pkt_rewind),
    .rd_en   (pkt_pop),
    .dout    (pkt_dout),
    .empty   (pkt_empty),
    .full    (unused_pkt_full),
    .used    (pkt_used)
  );

  ioq_pkt_fifo #(
    .WIDTH      (32),
    .DEPTH_BITS (LEN_FIFO_DEPTH_BITS),
    .COMMIT_EN  (1'b0)
  ) u_len_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (len_push),
    .din     ({pkt_words, pkt_bytes}),
    .commit  (1'b0),
    .rewind  (1'b0),
    .rd_en   (len_pop),
    .dout    (len_dout),
    .empty   (len_empty),
    .full    (len_full),
    .used    (unused_len_used)
  );

  // A packet's data is complete in the FIFO once its length entry exists, so DATA never starves.
  assign len_pop = (eg_state == EG_IDLE) & out_rdy & ~len_empty;
  assign pkt_pop = (eg_state == EG_DATA) & out_rdy & ~pkt_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eg_state <= EG_IDLE;
      out_wr   <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
    end else begin
      out_wr <= 1'b0;
      case (eg_state)
        EG_IDLE: begin
          if (len_pop) begin
            out_wr   <= 1'b1;
            out_data <= make_hdr(len_dout[15:0], len_dout[31:16], 16'(SRC_PORT_NUM));
            out_ctrl <= CTRL_WIDTH'(IO_QUEUE_STAGE_NUM);
            eg_state <= EG_DATA;
          end
        end
        EG_DATA: begin
          if (pkt_pop) begin
            out_wr   <= 1'b1;
            out_data <= pkt_dout[DATA_WIDTH-1:0];
            out_ctrl <= pkt_dout[CTRL_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
            if (pkt_dout[CTRL_WIDTH+DATA_WIDTH-1:DATA_WIDTH] != '0) eg_state <= EG_IDLE;
          end
        end
        default: eg_state <= EG_IDLE;
      endcase
    end
  end

endmodule
